// File: rtl/vend_panel_arbiter.sv
// Round-robin session arbiter sharing one vending core among NUM_PANELS front panels.
// Optional unfunded-session timeout is enabled by defining VEND_ARB_TIMEOUT_EN.
module vend_panel_arbiter #(
  parameter int NUM_PANELS     = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PANELS-1:0]   req,
  input  logic [8*NUM_PANELS-1:0] panel_coin,
  input  logic [3*NUM_PANELS-1:0] panel_drink,
  output logic [NUM_PANELS-1:0]   grant,
  output logic                    accept,
  output logic [NUM_PANELS-1:0]   panel_done,
  output logic [2:0]              result_drink,
  output logic [7:0]              result_change,
  output logic [7:0]              core_coin,
  output logic [2:0]              core_drink_choose,
  input  logic [2:0]              core_state,
  input  logic [7:0]              core_drink_out,
  input  logic [7:0]              core_exchange
);

  localparam int IW = (NUM_PANELS > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, owner_idx, pick_idx, cand;
  logic          pick_found;
  logic          timeout_hit;
  logic [7:0]    owner_coin;
  logic [2:0]    owner_drink;
  logic          unused_drink_hi;

  always_comb unused_drink_hi = ^core_drink_out[7:3];

  // Owner's inputs selected by the one-hot grant; non-owners never reach the core.
  always_comb begin
    owner_coin  = '0;
    owner_drink = '0;
    for (int unsigned i = 0; i < NUM_PANELS; i++) begin
      if (grant[i]) begin
        owner_coin  = panel_coin[8*i +: 8];
        owner_drink = panel_drink[3*i +: 3];
      end
    end
  end

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PANELS; k++) begin
      cand = IW'((32'(rr_ptr) + k) % 32'(NUM_PANELS));
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    core_coin         = '0;
    core_drink_choose = '0;
    panel_done        = '0;
    case (state)
      IDLE: if (pick_found) state_nxt = COLLECT;
      COLLECT: begin
        accept = (core_state <= 3'd1);
        if (accept) begin
          core_coin = owner_coin;
          if (core_state == 3'd1 && owner_coin == '0) core_drink_choose = owner_drink;
        end
        if (core_state == 3'd2) state_nxt = DISPENSE;
        else if (timeout_hit)   state_nxt = DONE;
      end
      DISPENSE: if (core_state == 3'd3) state_nxt = CHANGE;
      CHANGE:   if (core_state == 3'd0) state_nxt = DONE;
      DONE: begin
        panel_done = grant;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant         <= '0;
      owner_idx     <= '0;
      rr_ptr        <= '0;
      result_drink  <= '0;
      result_change <= '0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          grant     <= NUM_PANELS'(1) << pick_idx;
          owner_idx <= pick_idx;
        end
        COLLECT: if (timeout_hit && core_state != 3'd2) begin
          result_drink  <= '0;
          result_change <= '0;
        end
        DISPENSE: if (core_state == 3'd3) result_drink <= core_drink_out[2:0];
        CHANGE:   if (core_state == 3'd0) result_change <= core_exchange;
        DONE: begin
          rr_ptr <= IW'((32'(owner_idx) + 32'd1) % 32'(NUM_PANELS));
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef VEND_ARB_TIMEOUT_EN
  logic       funded;
  logic       owner_idle;
  logic [7:0] idle_cnt;

  always_comb begin
    owner_idle  = (owner_coin == '0) && (owner_drink == '0);
    timeout_hit = (state == COLLECT) && !funded && owner_idle &&
                  (idle_cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  // Counter and funded flag only live inside COLLECT; leaving it clears both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funded   <= 1'b0;
      idle_cnt <= '0;
    end else if (state == COLLECT) begin
      if (accept && owner_coin != '0) funded <= 1'b1;
      if (funded || !owner_idle || timeout_hit) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + 8'd1;
    end else begin
      funded   <= 1'b0;
      idle_cnt <= '0;
    end
  end
`else
  always_comb timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Randomized self-checking bench for vend_panel_arbiter with a behavioural vending core
// and a transaction-level reference (round-robin pick, price table, fixed core latency).
module tb_vend_panel_arbiter;
  localparam int NP = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] req;
  logic [8*NP-1:0] panel_coin;
  logic [3*NP-1:0] panel_drink;
  logic [NP-1:0] grant, panel_done;
  logic          accept;
  logic [2:0]    result_drink, core_drink_choose;
  logic [7:0]    result_change, core_coin;
  logic [2:0]    cs;
  logic [7:0]    core_drink_out, core_exchange;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int act_coin[$];
  int act_drink[$];
  int gap_cycles = 0;

  always #5 clk = ~clk;

  vend_panel_arbiter #(.NUM_PANELS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .panel_coin(panel_coin), .panel_drink(panel_drink),
    .grant(grant), .accept(accept), .panel_done(panel_done),
    .result_drink(result_drink), .result_change(result_change),
    .core_coin(core_coin), .core_drink_choose(core_drink_choose),
    .core_state(cs), .core_drink_out(core_drink_out), .core_exchange(core_exchange)
  );

  function automatic int price(input int d);
    case (d)
      1: return 10;
      2: return 15;
      3: return 20;
      4: return 25;
      default: return 255;
    endcase
  endfunction

  function automatic int coin_of(input int k);
    case (k)
      0: return 1;
      1: return 5;
      2: return 10;
      default: return 50;
    endcase
  endfunction

  // Vending core: a selection is taken one cycle before the core reports dispense.
  logic [7:0] total;
  logic       pend;
  logic [2:0] chosen;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs <= 3'd0; total <= '0; pend <= 1'b0; chosen <= '0;
      core_drink_out <= '0; core_exchange <= '0;
    end else begin
      case (cs)
        3'd0: if (core_coin != 0) begin total <= total + core_coin; cs <= 3'd1; end
        3'd1: begin
          if (pend) cs <= 3'd2;
          else if (core_coin != 0) total <= total + core_coin;
          else if (core_drink_choose != 0 && int'(total) >= price(int'(core_drink_choose))) begin
            pend <= 1'b1; chosen <= core_drink_choose;
          end
        end
        3'd2: begin cs <= 3'd3; pend <= 1'b0; core_drink_out <= {5'd0, chosen}; end
        default: begin
          cs <= 3'd0; core_exchange <= total - 8'(price(int'(chosen))); total <= '0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NP-1:0] r, input int ptr);
    for (int k = 0; k < NP; k++) if (r[(ptr + k) % NP]) return (ptr + k) % NP;
    return -1;
  endfunction

  task automatic drive(input int o, input int coin, input int drink);
    for (int i = 0; i < NP; i++) begin
      if (i == o) begin
        panel_coin[8*i +: 8]  = 8'(coin);
        panel_drink[3*i +: 3] = 3'(drink);
      end else begin
        panel_coin[8*i +: 8]  = 8'(coin_of($urandom_range(0, 3)));
        panel_drink[3*i +: 3] = 3'($urandom_range(0, 4));
      end
    end
  endtask

  task automatic set_script2(input int c0, input int d0, input int c1, input int d1);
    act_coin.delete(); act_drink.delete();
    act_coin.push_back(c0); act_drink.push_back(d0);
    act_coin.push_back(c1); act_drink.push_back(d1);
  endtask

  task automatic make_script();
    int d, p, nc, c;
    act_coin.delete(); act_drink.delete();
    d  = $urandom_range(1, 4);
    p  = 0;
    nc = $urandom_range(1, 3);
    for (int i = 0; i < nc; i++) begin
      c = coin_of($urandom_range(0, 3));
      act_coin.push_back(c); act_drink.push_back($urandom_range(0, 4));
      p += c;
    end
    if (p < price(d) && $urandom_range(0, 1) == 1) begin
      act_coin.push_back(0); act_drink.push_back(d);
    end
    while (p < price(d)) begin
      act_coin.push_back(10); act_drink.push_back(0); p += 10;
    end
    act_coin.push_back(0); act_drink.push_back(d);
  endtask

  // Entered #1 after an edge with the arbiter idle; leaves it idle again.
  task automatic run_session(input logic [NP-1:0] reqs, input bit drop_req);
    int o, paid, drk, n, exp_d;
    bit selected, got, saw_done;
    o = rr_pick(reqs, exp_ptr);
    req = reqs;
    drive(-1, 0, 0);
    @(posedge clk); #1;
    check("grant", grant, 1 << o);
    if (drop_req) req[o] = 1'b0;
    paid = 0; drk = 0; selected = 0; saw_done = 0;
    for (int a = 0; a < act_coin.size() && !selected; a++) begin
      drive(o, act_coin[a], act_drink[a]);
      #1;
      exp_d = (paid > 0 && act_coin[a] == 0) ? act_drink[a] : 0;
      check("accept", accept, 1);
      check("core_coin", core_coin, act_coin[a]);
      check("core_drink", core_drink_choose, exp_d);
      @(posedge clk); #1;
      if (act_coin[a] != 0) paid += act_coin[a];
      else if (act_drink[a] != 0 && paid > 0) begin
        if (paid >= price(act_drink[a])) begin selected = 1; drk = act_drink[a]; end
        else check("reject_held", grant | panel_done, 1 << o);
      end
      if (a == 0 && gap_cycles > 0) begin
        for (int g = 0; g < gap_cycles; g++) begin
          drive(o, 0, 0);
          @(posedge clk); #1;
          if (panel_done != 0) saw_done = 1;
        end
        check("no_timeout", saw_done, 0);
      end
    end
    check("selected", selected, 1);
    drive(o, 0, 0);
    @(posedge clk); #1;
    drive(o, 5, 0); #1;
    check("busy_accept", accept, 0);
    check("busy_coin", core_coin, 0);
    n = 0; got = 0;
    for (int k = 2; k <= 12 && !got; k++) begin
      @(posedge clk); #1;
      drive(o, 0, 0);
      if (panel_done != 0) begin got = 1; n = k; end
    end
    check("done_latency", n, 4);
    check("done_vec", panel_done, 1 << o);
    check("result_drink", result_drink, drk);
    check("result_change", result_change, paid - price(drk));
    exp_ptr = (o + 1) % NP;
    @(posedge clk); #1;
    check("grant_release", grant, 0);
    check("done_pulse", panel_done, 0);
  endtask

  initial begin
    int n;
    bit got, saw_done;
    reset = 1'b0; req = '0; panel_coin = '0; panel_drink = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_accept", accept, 0);
    check("rst_done", panel_done, 0);
    check("rst_rdrink", result_drink, 0);
    check("rst_rchange", result_change, 0);
    check("rst_coin", core_coin, 0);
    reset = 1'b1;

    set_script2(50, 0, 0, 4);
    run_session(4'b0011, 0);

    // Reset in the middle of panel 1's session.
    req = 4'b0010; drive(-1, 0, 0);
    @(posedge clk); #1;
    check("mid_grant", grant, 4'b0010);
    drive(1, 10, 0); #1;
    reset = 1'b0; #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_accept", accept, 0);
    check("mid_rst_coin", core_coin, 0);
    check("mid_rst_drink", core_drink_choose, 0);
    check("mid_rst_rdrink", result_drink, 0);
    check("mid_rst_rchange", result_change, 0);
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (panel_done != 0) saw_done = 1;
    end
    check("mid_rst_nodone", saw_done, 0);
    reset = 1'b1;
    exp_ptr = 0;

    set_script2(50, 0, 0, 4);
    run_session(4'b0011, 1);
    set_script2(10, 0, 5, 0);
    act_coin.push_back(0); act_drink.push_back(2);
    run_session(4'b0010, 0);
    set_script2(10, 0, 0, 3);
    act_coin.push_back(10); act_drink.push_back(0);
    act_coin.push_back(0);  act_drink.push_back(3);
    run_session(4'b0100, 0);
    make_script();
    run_session(4'b1000, 0);
    for (int s = 0; s < 5; s++) begin
      make_script();
      run_session(4'b1111, 0);
    end
    for (int s = 0; s < 12; s++) begin
      make_script();
      run_session(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

`ifdef VEND_ARB_TIMEOUT_EN
    req = 4'b1000; drive(-1, 0, 0);
    @(posedge clk); #1;
    check("to_grant", grant, 4'b1000);
    drive(3, 0, 0);
    n = 0; got = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      drive(3, 0, 0);
      if (panel_done != 0) begin got = 1; n = k; end
    end
    check("to_latency", n, TO);
    check("to_done", panel_done, 4'b1000);
    check("to_rdrink", result_drink, 0);
    check("to_rchange", result_change, 0);
    exp_ptr = 0;
    @(posedge clk); #1;
    check("to_release", grant, 0);
    set_script2(1, 0, 10, 0);
    act_coin.push_back(0); act_drink.push_back(1);
    gap_cycles = 3 * TO;
    run_session(4'b1000, 0);
    gap_cycles = 0;
`else
    set_script2(0, 0, 10, 0);
    act_coin.push_back(0); act_drink.push_back(1);
    gap_cycles = 3 * TO;
    run_session(4'b1000, 0);
    gap_cycles = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vend_panel_arbiter.md
# vend_panel_arbiter

Shares one vending-machine core between up to `NUM_PANELS` customer front panels. Only one panel owns the core at a time.

- Grants one panel a session, round-robin.
- Forwards that panel's coins and drink selection to the core, gated by core state, so no coin is presented while the core would drop it.
- Captures the dispensed drink and change, returns them to the owning panel, then releases the core.

It sits between the panel input logic and the vending core, and is the only driver of the core's `coin`/`drink_choose` inputs.

## Interface
- `NUM_PANELS`, 4: number of requesting panels, 2..4.
- `TIMEOUT_CYCLES`, 200: idle cycles before an unfunded session is revoked, 1..255.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_PANELS  session request per panel, level.
- `panel_coin`  in  8*NUM_PANELS  coin value per panel (0, 1, 5, 10, 50); slice i = bits [8i+7:8i].
- `panel_drink`  in  3*NUM_PANELS  drink selection per panel (0 none, 1..4).
- `grant`  out  NUM_PANELS  one-hot session owner; all-zero when idle.
- `accept`  out  1  granted panel's coin/drink is forwarded to the core this cycle.
- `panel_done`  out  NUM_PANELS  one-cycle pulse to the owner at session end.
- `result_drink`  out  3  drink dispensed (0 = none/timeout).
- `result_change`  out  8  change returned.
- `core_coin`  out  8  to core `coin`.
- `core_drink_choose`  out  3  to core `drink_choose`.
- `core_state`  in  3  core state (0 insert, 1 select, 2 dispense, 3 change).
- `core_drink_out`  in  8  core drink output.
- `core_exchange`  in  8  core change output.

## Operation
- Arbiter FSM states:
  - IDLE=0
  - COLLECT=1
  - DISPENSE=2
  - CHANGE=3
  - DONE=4
- **IDLE:** if any `req` is set, grant the first requester at or after `rr_ptr`, searching upward with wrap. Latch the one-hot `grant`, go to COLLECT.
- **COLLECT:**
  - `accept` = 1 iff `core_state` ∈ {0, 1}.
  - When `accept` is set:
    - `core_coin` = owner's `panel_coin`.
    - `core_drink_choose` = owner's `panel_drink` if `core_state` == 1 and the owner's coin == 0; otherwise 0.
  - All other cycles: `core_coin` = 0 and `core_drink_choose` = 0. Both outputs are combinational from `grant`/FSM/`core_state`.
  - A forwarded nonzero coin sets the `funded` flag.
  - `core_state` == 2 → DISPENSE.
- **DISPENSE:** `core_state` == 3 → capture `core_drink_out[2:0]` into `result_drink`, go to CHANGE.
- **CHANGE:** `core_state` == 0 → capture `core_exchange` into `result_change`, go to DONE.
- **DONE:**
  - Pulse `panel_done` for the owner.
  - Set `rr_ptr` = owner index + 1, mod `NUM_PANELS`.
  - Clear `grant` and `funded`, go to IDLE.
- A session is sticky: the owner deasserting `req` mid-session is ignored. A drink request the core rejects for insufficient funds leaves the core in 1 and the arbiter in COLLECT.
- Non-owner panel inputs are ignored entirely.
- Reset values: FSM IDLE, `rr_ptr` 0, `grant`/`panel_done`/`result_drink`/`result_change`/`funded`/timeout counter all 0. `core_coin`/`core_drink_choose`/`accept` are 0 by construction.
- Reset mid-session drops the session with no `panel_done`. The core shares the same reset.

## Timing
- Request→grant: `req` sampled at edge t, `grant` high from t+1.
- Core sequence after a selection accepted at edge t:
  - `core_state` 2 at t+1 (arbiter → DISPENSE at t+2).
  - `core_state` 3 at t+2: drink captured at edge t+3 (arbiter → CHANGE at t+3).
  - `core_state` 0 at t+3, `core_exchange` valid: change captured at edge t+4 (arbiter → DONE at t+4).
  - `panel_done` high during t+4; `grant` low from t+5.
- `result_drink`/`result_change` update on the edge entering DONE. They are valid during `panel_done` and held until the next DONE.
- Minimum one IDLE cycle between sessions.
- The owner still requesting at DONE loses to any other requester, because `rr_ptr` has advanced past it.

## Configuration
- `VEND_ARB_TIMEOUT_EN` defined:
  - In COLLECT with `funded` = 0, an 8-bit counter increments each cycle the owner's coin and drink are both 0; it is cleared by any nonzero input.
  - Reaching `TIMEOUT_CYCLES` → DONE with `result_drink` = 0 and `result_change` = 0.
  - Funded sessions never time out.
- Undefined: no counter; sessions are held until the core completes.

## Test plan
- Reset mid-COLLECT with `grant` = 0010 → next cycle all outputs 0, FSM IDLE, `rr_ptr` 0, no `panel_done`.
- Panel 1 alone: coin 10, then coin 5, then drink 2 → `panel_done`[1] pulses with `result_drink` 2 and `result_change` 0, exactly 4 cycles after the selection edge.
- Panel 0: coin 50, drink 4 → `result_drink` 4, `result_change` 25. Coin 5 driven while `core_state` is 2 gives `accept` 0 and `core_coin` 0, and the core total is unaffected.
- `req` = 1111 held continuously → grants 0001, 0010, 0100, 1000, 0001 in order; each session completes with its own results.
- Panel 2 granted, drink 3 with only 10 inserted → core stays 1, arbiter stays COLLECT. Coin 10 then drink 3 → `result_drink` 3, `result_change` 0.
- `VEND_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20, panel 3 granted with no input → `panel_done`[3] after 20 idle cycles, results 0. Same with one coin 1 → no timeout.
